// File: rtl/alct_prbs_checker.sv
// rtl/alct_prbs_checker.sv - ALCT 49-bit PRBS checker with hunt/lock FSM and saturating error counters
module alct_prbs_checker #(
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        rx_valid,
    input  logic [48:0] rx_data,
    input  logic        clear_cnt,
    output logic        locked,
    output logic        err_pulse,
    output logic [48:0] err_bits,
    output logic [31:0] word_cnt,
    output logic [31:0] err_cnt,
    output logic [7:0]  lost_lock_cnt
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int UW = $clog2(UNLOCK_CNT + 1);

    typedef enum logic [1:0] {S_IDLE, S_HUNT, S_LOCKED} state_t;

    function automatic logic [48:0] prbs_next(input logic [48:0] w);
        return {w[47:0], ~(w[48] ^ w[39])};
    endfunction

    state_t         state_q, state_d;
    logic [MW-1:0]  match_cnt_q, match_cnt_d;
    logic [UW-1:0]  miss_cnt_q, miss_cnt_d;
    logic [48:0]    pred_q, pred_d;
    logic           pred_valid_q, pred_valid_d;
    logic [48:0]    exp_q, exp_d;
    logic           locked_q, locked_d;
    logic           err_pulse_q, err_pulse_d;
    logic [48:0]    err_bits_q, err_bits_d;
    logic [31:0]    word_cnt_q, word_cnt_d;
    logic [31:0]    err_cnt_q, err_cnt_d;
    logic [7:0]     lost_lock_cnt_q, lost_lock_cnt_d;
    logic [MW-1:0]  match_inc;
    logic [UW-1:0]  miss_inc;

    always_comb begin
        state_d         = state_q;
        match_cnt_d     = match_cnt_q;
        miss_cnt_d      = miss_cnt_q;
        pred_d          = pred_q;
        pred_valid_d    = pred_valid_q;
        exp_d           = exp_q;
        err_pulse_d     = 1'b0;
        err_bits_d      = err_bits_q;
        word_cnt_d      = word_cnt_q;
        err_cnt_d       = err_cnt_q;
        lost_lock_cnt_d = lost_lock_cnt_q;
        match_inc       = match_cnt_q + MW'(1);
        miss_inc        = miss_cnt_q + UW'(1);

        if (!ce) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d      = S_HUNT;
                    match_cnt_d  = '0;
                    pred_valid_d = 1'b0;
                end
                S_HUNT: begin
                    if (rx_valid) begin
                        // Reseed the predictor from every received word while hunting
                        match_cnt_d  = (pred_valid_q && rx_data == pred_q) ? match_inc : '0;
                        pred_d       = prbs_next(rx_data);
                        pred_valid_d = 1'b1;
                        if (match_cnt_d == MW'(LOCK_CNT)) begin
                            state_d    = S_LOCKED;
                            exp_d      = prbs_next(rx_data);
                            miss_cnt_d = '0;
                        end
                    end
                end
                S_LOCKED: begin
                    if (rx_valid) begin
                        err_bits_d = rx_data ^ exp_q;
                        exp_d      = prbs_next(exp_q);
                        word_cnt_d = (word_cnt_q == '1) ? word_cnt_q : word_cnt_q + 32'd1;
                        if (rx_data != exp_q) begin
                            err_pulse_d = 1'b1;
                            err_cnt_d   = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 32'd1;
                            miss_cnt_d  = miss_inc;
                            if (miss_inc == UW'(UNLOCK_CNT)) begin
                                state_d         = S_HUNT;
                                match_cnt_d     = '0;
                                pred_valid_d    = 1'b0;
                                miss_cnt_d      = '0;
                                lost_lock_cnt_d = (lost_lock_cnt_q == '1) ? lost_lock_cnt_q
                                                                          : lost_lock_cnt_q + 8'd1;
                            end
                        end else begin
                            miss_cnt_d = '0;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (clear_cnt) begin
            word_cnt_d      = '0;
            err_cnt_d       = '0;
            lost_lock_cnt_d = '0;
        end

        locked_d = (state_d == S_LOCKED);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            match_cnt_q     <= '0;
            miss_cnt_q      <= '0;
            pred_q          <= '0;
            pred_valid_q    <= 1'b0;
            exp_q           <= '0;
            locked_q        <= 1'b0;
            err_pulse_q     <= 1'b0;
            err_bits_q      <= '0;
            word_cnt_q      <= '0;
            err_cnt_q       <= '0;
            lost_lock_cnt_q <= '0;
        end else begin
            state_q         <= state_d;
            match_cnt_q     <= match_cnt_d;
            miss_cnt_q      <= miss_cnt_d;
            pred_q          <= pred_d;
            pred_valid_q    <= pred_valid_d;
            exp_q           <= exp_d;
            locked_q        <= locked_d;
            err_pulse_q     <= err_pulse_d;
            err_bits_q      <= err_bits_d;
            word_cnt_q      <= word_cnt_d;
            err_cnt_q       <= err_cnt_d;
            lost_lock_cnt_q <= lost_lock_cnt_d;
        end
    end

    assign locked        = locked_q;
    assign err_pulse     = err_pulse_q;
    assign err_bits      = err_bits_q;
    assign word_cnt      = word_cnt_q;
    assign err_cnt       = err_cnt_q;
    assign lost_lock_cnt = lost_lock_cnt_q;

endmodule

// File: doc/alct_prbs_checker.md
ALCT_PRBS_CHECKER -- requirements
Module: alct_prbs_checker

Interface
REQ-001 The block SHALL have parameter LOCK_CNT, default 8, giving the number of consecutive correctly predicted words needed to declare lock.
REQ-002 The block SHALL have parameter UNLOCK_CNT, default 4, giving the number of consecutive mismatched words in LOCKED that declare loss of lock.
REQ-003 The block SHALL have port clock, input, 1, the 40 MHz clock; it is the only clock.
REQ-004 The block SHALL have port reset_n, input, 1, a synchronous active-low reset.
REQ-005 The block SHALL have port ce, input, 1, the checker enable.
REQ-006 The block SHALL have port rx_valid, input, 1, which qualifies rx_data.
REQ-007 The block SHALL have port rx_data, input, 49, the received 49-bit ALCT PRBS word.
REQ-008 The block SHALL have port clear_cnt, input, 1, a pulse that zeroes all counters.
REQ-009 The block SHALL have port locked, output, 1, high while in LOCKED.
REQ-010 The block SHALL have port err_pulse, output, 1, a one-cycle flag for a mismatched word.
REQ-011 The block SHALL have port err_bits, output, 49, the XOR of the received and expected word, held from the last checked word.
REQ-012 The block SHALL have port word_cnt, output, 32, the count of words checked in LOCKED, saturating.
REQ-013 The block SHALL have port err_cnt, output, 32, the count of mismatched words, saturating.
REQ-014 The block SHALL have port lost_lock_cnt, output, 8, the count of LOCKED-to-HUNT transitions, saturating.

Function
REQ-015 next(w) SHALL equal {w[47:0], ~(w[48]^w[39])}, the 49-bit generator sequence.
REQ-016 States SHALL be IDLE, HUNT and LOCKED; only rx_valid cycles SHALL advance HUNT/LOCKED logic.
REQ-017 IDLE: when ce=1, the state SHALL go to HUNT on the next clock with match count=0 and prediction-valid flag=0.
REQ-018 From any state, ce=0 SHALL force IDLE on the next clock; the counters SHALL hold.
REQ-019 HUNT, on rx_valid: if the prediction is valid and rx_data equals the prediction, the match count SHALL increment; otherwise the match count SHALL be set to 0.
REQ-020 HUNT, on every rx_valid: the prediction SHALL be loaded with next(rx_data), and the prediction-valid flag SHALL be set to 1.
REQ-021 HUNT: when the match count reaches LOCK_CNT, the state SHALL go to LOCKED, and the expected register SHALL be loaded with next(rx_data) of the word that completed the count.
REQ-022 In HUNT, word_cnt and err_cnt SHALL NOT change and err_pulse SHALL be 0.
REQ-023 LOCKED, on rx_valid: the received word SHALL be compared with the expected register, and the expected register SHALL then load next(expected), never reseeding from rx_data.
REQ-024 LOCKED, on rx_valid: word_cnt SHALL increment by 1, and err_bits SHALL load rx_data XOR expected.
REQ-025 LOCKED, on a mismatch: err_pulse SHALL be 1 for one cycle, err_cnt SHALL increment by 1, and the consecutive-miss count SHALL increment by 1.
REQ-026 LOCKED, on a match: the consecutive-miss count SHALL be set to 0.
REQ-027 LOCKED: when the consecutive-miss count reaches UNLOCK_CNT, the state SHALL go to HUNT with cleared match state, and lost_lock_cnt SHALL increment by 1.
REQ-028 err_pulse, err_bits and the counters SHALL update on the clock edge that samples rx_valid, giving a latency of 1 cycle.
REQ-029 Counters SHALL saturate at their all-ones value and never wrap.
REQ-030 clear_cnt SHALL win over a simultaneous increment; state and lock SHALL be unaffected by clear_cnt.
REQ-031 rx_valid=0 in HUNT or LOCKED SHALL freeze all state, with no timeout.

Reset
REQ-032 reset_n=0 at a clock edge SHALL give: state IDLE; locked=0, err_pulse=0, err_bits=0, word_cnt=0, err_cnt=0, lost_lock_cnt=0; match/miss counts, prediction and expected=0.
REQ-033 Reset SHALL take priority over ce and clear_cnt, and SHALL abort any state mid-operation.

Verification
REQ-034 Seed stream 49'h123456789ABCD, rx_valid every cycle, ce=1 -> locked rises after LOCK_CNT+1 valid words; second word = 49'h0468ACF13579A.
REQ-035 Locked, corrupt bit 0 of one word -> err_pulse for 1 cycle, err_bits=49'h1, err_cnt=1, locked stays 1.
REQ-036 Locked, 4 consecutive corrupt words -> locked falls after the 4th, lost_lock_cnt=1, err_cnt=4, state HUNT; clean stream relocks.
REQ-037 Locked, rx_valid gaps of 1-5 cycles -> no errors, word_cnt equals the number of valid words.
REQ-038 Preload word_cnt near 32'hFFFFFFFF via a long run or force -> it sticks at 32'hFFFFFFFF; clear_cnt with a coincident error -> err_cnt=0.
REQ-039 reset_n=0 for 1 cycle while locked -> all outputs 0 next cycle, state IDLE, then HUNT with ce=1.
